rcv_nrzi_unstuff: RTL

Parametrised successor to the receiver's NRZI decoder. It combines NRZI decoding with bit-unstuffing, SE0/EOP detection and word assembly. It sits between the D+/D- synchronisers / bit-timer and the receive control FSM and RX FIFO. It consumes one line sample per shift_enable strobe and emits decoded bits, completed WORD_W-bit words, stuff-error, line-error and end-of-packet indications.

---
 rtl/rcv_nrzi_unstuff.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rcv_nrzi_unstuff.sv
// rtl/rcv_nrzi_unstuff.sv - NRZI decoder with bit unstuffing, SE0/EOP detection and word assembly
module rcv_nrzi_unstuff #(
    parameter int   STUFF_LEN  = 6,
    parameter int   WORD_W     = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_enable,
    input  logic              d_plus_sync,
    input  logic              d_minus_sync,
    input  logic              packet_done,
    output logic              d_prim,
    output logic              bit_valid,
    output logic              bit_out,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              stuff_err,
    output logic              line_err,
    output logic              eop,
    output logic              eop_partial
);

    localparam int              BCW       = $clog2(WORD_W);
    localparam logic [3:0]      STUFF_MAX = 4'(STUFF_LEN);
    localparam logic [BCW-1:0]  LAST_BIT  = BCW'(WORD_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_SE0_1, S_SE0_2} state_t;

    state_t            r_state, w_state_nx;
    logic              r_prev_level, w_prev_level_nx;
    logic [3:0]        r_ones_cnt, w_ones_cnt_nx;
    logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_nx;
    logic [WORD_W-1:0] r_shift_reg, w_shift_reg_nx, w_shifted;
    logic [WORD_W-1:0] w_word_nx;
    logic              w_se0, w_j, w_accept;
    logic              w_bit_valid_nx, w_bit_out_nx, w_word_valid_nx;
    logic              w_stuff_err_nx, w_line_err_nx, w_eop_nx, w_eop_partial_nx;

    assign w_se0     = !d_plus_sync && !d_minus_sync;
    assign w_j       = d_plus_sync && !d_minus_sync;
    assign d_prim    = ~(r_prev_level ^ d_plus_sync);
    assign w_shifted = {d_prim, r_shift_reg[WORD_W-1:1]};

    always_comb begin
        w_state_nx       = r_state;
        w_prev_level_nx  = r_prev_level;
        w_ones_cnt_nx    = r_ones_cnt;
        w_bit_cnt_nx     = r_bit_cnt;
        w_shift_reg_nx   = r_shift_reg;
        w_word_nx        = word_out;
        w_bit_out_nx     = bit_out;
        w_accept         = 1'b0;
        w_bit_valid_nx   = 1'b0;
        w_word_valid_nx  = 1'b0;
        w_stuff_err_nx   = 1'b0;
        w_line_err_nx    = 1'b0;
        w_eop_nx         = 1'b0;
        w_eop_partial_nx = 1'b0;

        if (packet_done) begin
            w_prev_level_nx = d_plus_sync;
            w_ones_cnt_nx   = '0;
            w_bit_cnt_nx    = '0;
            w_state_nx      = S_IDLE;
        end else if (shift_enable) begin
            if (!w_se0)
                w_prev_level_nx = d_plus_sync;
            unique case (r_state)
                S_IDLE: begin
                    // first line transition out of idle is itself the first data bit
                    if (!w_se0 && !d_prim) begin
                        w_state_nx = S_ACTIVE;
                        w_accept   = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_se0) begin
                        w_state_nx = S_SE0_1;
                    end else if (r_ones_cnt == STUFF_MAX) begin
                        w_ones_cnt_nx  = '0;
                        w_stuff_err_nx = d_prim;
                    end else begin
                        w_accept = 1'b1;
                    end
                end
                S_SE0_1: begin
                    if (w_se0) begin
                        w_state_nx = S_SE0_2;
                    end else begin
                        w_line_err_nx = 1'b1;
                        w_state_nx    = S_IDLE;
                        w_ones_cnt_nx = '0;
                        w_bit_cnt_nx  = '0;
                    end
                end
                S_SE0_2: begin
                    if (w_j) begin
                        w_eop_nx         = 1'b1;
                        w_eop_partial_nx = (r_bit_cnt != '0);
                        w_prev_level_nx  = 1'b1;
                    end else begin
                        w_line_err_nx = 1'b1;
                    end
                    w_state_nx    = S_IDLE;
                    w_ones_cnt_nx = '0;
                    w_bit_cnt_nx  = '0;
                end
                default: w_state_nx = S_IDLE;
            endcase

            if (w_accept) begin
                w_shift_reg_nx = w_shifted;
                w_bit_valid_nx = 1'b1;
                w_bit_out_nx   = d_prim;
                w_ones_cnt_nx  = d_prim ? r_ones_cnt + 4'd1 : 4'd0;
                if (r_bit_cnt == LAST_BIT) begin
                    w_word_nx       = w_shifted;
                    w_word_valid_nx = 1'b1;
                    w_bit_cnt_nx    = '0;
                end else begin
                    w_bit_cnt_nx = r_bit_cnt + BCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev_level <= IDLE_LEVEL;
            r_ones_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift_reg  <= '0;
            word_out     <= '0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            word_valid   <= 1'b0;
            stuff_err    <= 1'b0;
            line_err     <= 1'b0;
            eop          <= 1'b0;
            eop_partial  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_prev_level <= w_prev_level_nx;
            r_ones_cnt   <= w_ones_cnt_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_shift_reg  <= w_shift_reg_nx;
            word_out     <= w_word_nx;
            bit_out      <= w_bit_out_nx;
            bit_valid    <= w_bit_valid_nx;
            word_valid   <= w_word_valid_nx;
            stuff_err    <= w_stuff_err_nx;
            line_err     <= w_line_err_nx;
            eop          <= w_eop_nx;
            eop_partial  <= w_eop_partial_nx;
        end
    end

endmodule
